seg7_scan_controller: RTL
=========================

Name: seg7_scan_controller

Overview:
- Time-multiplexes the 4-digit seven-segment display on the board, one digit at a time.
- Inserts an all-anodes-off ghosting gap between digits and supports per-digit blanking, decimal points and leading-zero suppression.
- Accepts new display values through a load/ack handshake. Values are committed only at a frame boundary, so a frame never shows mixed old and new digits.
- Sits between the top-level datapath (switch/value logic) and the CA..CG, DP and AN1..AN4 pins.

Parameters:
- TICKS_PER_DIGIT, default 100000: clk cycles each digit is driven (1 ms at 100 MHz); must be ≥1.
- BLANK_TICKS, default 2000: clk cycles with all anodes off before each digit; 0 removes the gap.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-low reset.
- value  in  16  four hex nibbles; [3:0] is digit0 (AN1, rightmost), [15:12] is digit3 (AN4).
- dp_in  in  4  decimal point per digit, 1 = lit.
- blank_in  in  4  force digit dark, 1 = blank.
- lz_suppress  in  1  1 = suppress leading zeros.
- load  in  1  request to stage value, dp_in and blank_in.
- load_ack  out  1  one-cycle pulse when staged data is committed to display.
- frame_start  out  1  one-cycle pulse at the start of each frame.
- seg  out  7  active-low segments; [0]=CA … [6]=CG.
- dp  out  1  active-low decimal point.
- an  out  4  active-low anodes; [0]=AN1 … [3]=AN4.

Behaviour:
- Reset, sampled at posedge while reset=0:
  - an=4'b1111, seg=7'b1111111, dp=1, load_ack=0, frame_start=0.
  - Digit index=0, tick counter=0, state=BLANK.
  - Staging and display registers cleared to 0; pending=0.
  - load is ignored while in reset.
- All outputs are registered.
- States:
  - BLANK lasts BLANK_TICKS cycles: an=1111, seg=1111111, dp=1. It is skipped entirely when BLANK_TICKS=0.
  - DRIVE lasts TICKS_PER_DIGIT cycles: the anode of the current digit is low, seg/dp carry that digit.
- Transitions:
  - BLANK → DRIVE when the counter reaches BLANK_TICKS-1.
  - DRIVE → BLANK (next digit) when the counter reaches TICKS_PER_DIGIT-1.
  - Digit index runs 0→1→2→3→0, wrapping.
- Frame length is 4*(BLANK_TICKS+TICKS_PER_DIGIT) cycles.
- After reset release, the first output cycle is BLANK of digit0.
- Frame boundary = first output cycle of digit0's slot (BLANK, or DRIVE if BLANK_TICKS=0), including the first slot after reset.
  - frame_start=1 on that cycle.
- Load handshake:
  - load=1 in any cycle copies value, dp_in and blank_in into the staging register and sets pending.
  - If several loads occur before a boundary, the last one wins.
  - At a frame boundary with pending=1, staging is copied to the display register, load_ack=1 for that one cycle, and pending clears.
  - If load=1 on a commit cycle, the previous staging contents are committed; the new data is staged and pending stays 1 for the next frame.
- Digit dark rule: digit i is dark (anode stays 1, seg=1111111, dp=1) during its DRIVE slot if either of these holds:
  - blank_in[i] (display copy) is set, or
  - lz_suppress=1, i≥1, and nibbles i..3 of the display value are all 0.
- Digit0 is never zero-suppressed.
- lz_suppress is read live, not staged.
- Hex decode is standard 0–F, active-low. Examples as seg[6:0]:
  - 0 = 1000000
  - 1 = 1111001
  - 7 = 1111000
  - 8 = 0000000
  - A = 0001000
  - F = 0001110
- dp output = ~dp_in[i] (display copy) while digit i is driven and not dark.
- Counter width = $clog2(max(TICKS_PER_DIGIT, BLANK_TICKS, 2)).
- Reset asserted mid-DRIVE forces reset values at the next edge; no partial digit is carried over.

Decomposition:
- Shared package seg7_pkg:
  - state enum {BLANK, DRIVE}.
  - Constants SEG_OFF=7'h7F and AN_OFF=4'hF.
  - 16-entry hex→segment constant array.
- Sub-module seg7_decoder (combinational, 4-bit nibble → 7-bit active-low pattern), instantiated once on the selected nibble.

Test Plan:
Bench parameters TICKS_PER_DIGIT=4, BLANK_TICKS=1.
1. Reset: hold reset=0 for 3 cycles with load=1 and value=16'h1234, then release → an=1111, seg=1111111, dp=1, load_ack never pulses; display shows 0000 (digit0 seg=1000000; digits 1–3 also 1000000 with lz_suppress=0).
2. Scan order: load 16'h8A71, lz_suppress=0 → load_ack at the next boundary; an sequence per 20-cycle frame is 1111×1, 1110×4 (seg=1111001), 1111×1, 1101×4 (1111000), 1111×1, 1011×4 (0001000), 1111×1, 0111×4 (0000000); frame_start period = 20 cycles.
3. Leading zeros: load 16'h0070, lz_suppress=1 → digits 3 and 2 dark (an=1111 throughout their slots), digit1 seg=1111000, digit0 seg=1000000. Then load 16'h0000 → only digit0 lit.
4. Handshake: mid-frame, load 16'hABCD, then 16'h000F two cycles later → display unchanged until the boundary; exactly one load_ack pulse; the next frame shows 000F. load on the ack cycle → second ack exactly 20 cycles later.
5. blank_in=4'b0100 with dp_in=4'b0001 and value 16'h1111 → digit2 dark; digit0 dp=0; other digits dp=1.
6. Reset pulse during digit2's DRIVE → next edge an=1111 and seg=1111111; after release, scan restarts at digit0 with display=0000.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg7_pkg;

    // Scan phase of the current digit slot.
    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low segment patterns, bit 0 = CA ... bit 6 = CG.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Table lookup of the segment pattern for the nibble.
    always_comb begin
        seg_o = HEX_SEG[nibble_i];
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Four-digit seven-segment scan controller with ghosting gap, blanking,
// leading-zero suppression and frame-aligned load/ack value updates.
//
// The position registers (state_q, digit_q, cnt_q) hold the slot position
// that the output registers will present after the next clock edge, so the
// output flops are loaded from a decode of that position.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_TICKS     = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        lz_suppress,
    input  logic        load,
    output logic        load_ack,
    output logic        frame_start,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int CNT_BIG   = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
    localparam int CNT_MAX   = (CNT_BIG > 2) ? CNT_BIG : 2;
    localparam int CNT_W     = $clog2(CNT_MAX);
    localparam bit HAS_BLANK = (BLANK_TICKS > 0);

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? (BLANK_TICKS - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Slot position
    state_e           state_q, state_d;
    logic [1:0]       digit_q, digit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Staging and display copies of the loaded data
    logic [15:0] stg_val_q, stg_val_d;
    logic [3:0]  stg_dp_q, stg_dp_d;
    logic [3:0]  stg_bl_q, stg_bl_d;
    logic        pend_q, pend_d;
    logic [15:0] disp_val_q, disp_val_d;
    logic [3:0]  disp_dp_q, disp_dp_d;
    logic [3:0]  disp_bl_q, disp_bl_d;

    // Registered outputs
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic [3:0] an_q, an_d;
    logic       load_ack_q;
    logic       frame_start_q;

    // Decode helpers
    state_e     emit_state_s;
    logic       boundary_s;
    logic       commit_s;
    logic [3:0] nibble_s;
    logic [6:0] dec_seg_s;
    logic       lz_dark_s;
    logic       dark_s;
    logic       drive_on_s;

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;

    seg7_decoder u_decoder (
        .nibble_i (nibble_s),
        .seg_o    (dec_seg_s)
    );

    // Effective phase of the position and whether it opens a new frame.
    always_comb begin
        if (HAS_BLANK) begin
            emit_state_s = state_q;
        end else begin
            emit_state_s = DRIVE;
        end
        boundary_s = (digit_q == 2'd0) && (cnt_q == CNT_ZERO) &&
                     ((emit_state_s == BLANK) || !HAS_BLANK);
        commit_s   = boundary_s && pend_q;
    end

    // Advance the slot position by one clock.
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        cnt_d   = cnt_q;
        case (emit_state_s)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    if (HAS_BLANK) begin
                        state_d = BLANK;
                    end else begin
                        state_d = DRIVE;
                    end
                    digit_d = digit_q + 2'd1;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = BLANK;
                digit_d = 2'd0;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Staging capture, pending flag and frame-boundary commit.
    always_comb begin
        if (load) begin
            stg_val_d = value;
            stg_dp_d  = dp_in;
            stg_bl_d  = blank_in;
            pend_d    = 1'b1;
        end else begin
            stg_val_d = stg_val_q;
            stg_dp_d  = stg_dp_q;
            stg_bl_d  = stg_bl_q;
            pend_d    = pend_q && !commit_s;
        end
        if (commit_s) begin
            disp_val_d = stg_val_q;
            disp_dp_d  = stg_dp_q;
            disp_bl_d  = stg_bl_q;
        end else begin
            disp_val_d = disp_val_q;
            disp_dp_d  = disp_dp_q;
            disp_bl_d  = disp_bl_q;
        end
    end

    // Select the digit nibble and work out whether the digit is dark.
    always_comb begin
        case (digit_q)
            2'd0: begin
                nibble_s  = disp_val_d[3:0];
                lz_dark_s = 1'b0;
            end
            2'd1: begin
                nibble_s  = disp_val_d[7:4];
                lz_dark_s = (disp_val_d[15:4] == 12'h000);
            end
            2'd2: begin
                nibble_s  = disp_val_d[11:8];
                lz_dark_s = (disp_val_d[15:8] == 8'h00);
            end
            2'd3: begin
                nibble_s  = disp_val_d[15:12];
                lz_dark_s = (disp_val_d[15:12] == 4'h0);
            end
            default: begin
                nibble_s  = 4'h0;
                lz_dark_s = 1'b0;
            end
        endcase
        dark_s     = disp_bl_d[digit_q] || (lz_suppress && lz_dark_s);
        drive_on_s = (emit_state_s == DRIVE) && !dark_s;
    end

    // Pin values for the position about to be presented.
    always_comb begin
        if (drive_on_s) begin
            an_d  = ~(4'b0001 << digit_q);
            seg_d = dec_seg_s;
            dp_d  = ~disp_dp_d[digit_q];
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
        end
    end

    // Scan FSM with registered pin outputs and handshake pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= BLANK;
            digit_q       <= 2'd0;
            cnt_q         <= CNT_ZERO;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            digit_q       <= digit_d;
            cnt_q         <= cnt_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            load_ack_q    <= commit_s;
            frame_start_q <= boundary_s;
        end
    end

    // Staging and display data registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stg_val_q  <= 16'h0000;
            stg_dp_q   <= 4'h0;
            stg_bl_q   <= 4'h0;
            pend_q     <= 1'b0;
            disp_val_q <= 16'h0000;
            disp_dp_q  <= 4'h0;
            disp_bl_q  <= 4'h0;
        end else begin
            stg_val_q  <= stg_val_d;
            stg_dp_q   <= stg_dp_d;
            stg_bl_q   <= stg_bl_d;
            pend_q     <= pend_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            disp_bl_q  <= disp_bl_d;
        end
    end

endmodule
